// File: rtl/reg_file_if.sv
// reg_file_if: write, read, memory-load and data-memory signals of the register file
interface reg_file_if;
  logic        C_EN;
  logic [3:0]  C_SEL;
  logic [18:0] c_in;
  logic [3:0]  A_SEL;
  logic [3:0]  B_SEL;
  logic        MEM_READ;
  logic [7:0]  mem_data;
  logic [18:0] a_out;
  logic [18:0] b_out;
  logic [18:0] dm_addr;
  logic [7:0]  dm_data;
  modport master (
    output C_EN, C_SEL, c_in, A_SEL, B_SEL, MEM_READ, mem_data,
    input  a_out, b_out, dm_addr, dm_data
  );
  modport slave (
    input  C_EN, C_SEL, c_in, A_SEL, B_SEL, MEM_READ, mem_data,
    output a_out, b_out, dm_addr, dm_data
  );
endinterface

// File: rtl/reg_file.sv
// reg_file: 16x19 register file (R0=AR, R1=DR) with memory load and scoped async clear
module reg_file (
  input  logic       clk,
  input  logic       RST,
  input  logic [3:0] RST_SEL,
  reg_file_if.slave  bus
);
  logic [18:0] rf [16];
  for (genvar i = 0; i < 16; i++) begin : g_r
    logic        clr;
    logic [18:0] q;
    // each register gets its own async clear so a scoped reset leaves the others running
    assign clr = RST && (RST_SEL == 4'd0 || RST_SEL == 4'(i));
    always_ff @(posedge clk or posedge clr)
      if (clr) q <= '0;
      else if (i == 1 && bus.MEM_READ) q <= {11'b0, bus.mem_data};
      else if (bus.C_EN && bus.C_SEL == 4'(i)) q <= bus.c_in;
    assign rf[i] = q;
  end
  assign bus.a_out   = rf[bus.A_SEL];
  assign bus.b_out   = rf[bus.B_SEL];
  assign bus.dm_addr = rf[0];
  assign bus.dm_data = rf[1][7:0];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed stimulus with a queue scoreboard checked by a separate monitor
module tb_reg_file;
  logic       clk = 0;
  logic       RST;
  logic [3:0] RST_SEL;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [64:0] exp_q [$];
  string       name_q [$];
  event        sample_ev;

  reg_file_if bus ();
  reg_file dut (.clk(clk), .RST(RST), .RST_SEL(RST_SEL), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(sample_ev);
      #1;
      if (exp_q.size() != 0) begin
        logic [64:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_tests++;
        if ({bus.a_out, bus.b_out, bus.dm_addr, bus.dm_data} !== e) begin
          n_fail++;
          $display("FAIL %s: got a=%h b=%h addr=%h data=%h, expected a=%h b=%h addr=%h data=%h",
                   nm, bus.a_out, bus.b_out, bus.dm_addr, bus.dm_data,
                   e[64:46], e[45:27], e[26:8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] as, input logic [3:0] bs,
                     input logic [18:0] a, input logic [18:0] b,
                     input logic [18:0] ad, input logic [7:0] d);
    bus.A_SEL = as;
    bus.B_SEL = bs;
    exp_q.push_back({a, b, ad, d});
    name_q.push_back(nm);
    -> sample_ev;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] sel, input logic [18:0] v);
    bus.C_EN = 1; bus.C_SEL = sel; bus.c_in = v;
    tick();
    bus.C_EN = 0;
  endtask

  task automatic mem_ld(input logic [7:0] d);
    bus.MEM_READ = 1; bus.mem_data = d;
    tick();
    bus.MEM_READ = 0;
  endtask

  initial begin
    RST = 1; RST_SEL = 0;
    bus.C_EN = 0; bus.C_SEL = 0; bus.c_in = 0;
    bus.A_SEL = 0; bus.B_SEL = 0; bus.MEM_READ = 0; bus.mem_data = 0;
    chk("reset_all", 0, 5, 0, 0, 0, 0);
    RST = 0;
    wr(1, 19'd10);
    chk("write_read", 1, 0, 19'd10, 0, 0, 8'd10);
    mem_ld(8'hA5);
    chk("mem_load", 1, 1, 19'h000A5, 19'h000A5, 0, 8'hA5);
    bus.C_EN = 1; bus.C_SEL = 1; bus.c_in = 19'd7;
    mem_ld(8'h3C);
    bus.C_EN = 0;
    chk("mem_wins_r1", 1, 1, 19'h0003C, 19'h0003C, 0, 8'h3C);
    bus.C_EN = 1; bus.C_SEL = 2; bus.c_in = 19'h00222;
    mem_ld(8'h5A);
    bus.C_EN = 0;
    chk("mem_and_write", 1, 2, 19'h0005A, 19'h00222, 0, 8'h5A);
    wr(0, 19'h7FFFF);
    wr(5, 19'h12345);
    chk("pre_sel_clear", 5, 0, 19'h12345, 19'h7FFFF, 19'h7FFFF, 8'h5A);
    bus.C_EN = 1; bus.C_SEL = 6; bus.c_in = 19'h00666;
    bus.MEM_READ = 1; bus.mem_data = 8'h11;
    RST_SEL = 5; RST = 1;
    chk("sel_clear_async", 5, 0, 0, 19'h7FFFF, 19'h7FFFF, 8'h5A);
    tick();
    bus.C_EN = 0; bus.MEM_READ = 0;
    chk("sel_clear_others_write", 5, 6, 0, 19'h00666, 19'h7FFFF, 8'h11);
    RST = 0;
    chk("sel_clear_release", 5, 6, 0, 19'h00666, 19'h7FFFF, 8'h11);
    wr(3, 19'h11111);
    bus.C_EN = 1; bus.C_SEL = 3; bus.c_in = 19'h55555;
    chk("no_bypass_old", 3, 3, 19'h11111, 19'h11111, 19'h7FFFF, 8'h11);
    tick();
    bus.C_EN = 0;
    chk("no_bypass_new", 3, 3, 19'h55555, 19'h55555, 19'h7FFFF, 8'h11);
    for (int i = 0; i < 16; i++) wr(4'(i), 19'(i * 19'h1111 + 19'h10));
    chk("fill", 15, 2, 19'h1000F, 19'h02232, 19'h00010, 8'h21);
    bus.C_EN = 1; bus.C_SEL = 9; bus.c_in = 19'h00999;
    RST_SEL = 0; RST = 1;
    chk("global_clear_async", 9, 0, 0, 0, 0, 0);
    for (int i = 1; i < 16; i++) chk("global_clear_reg", 4'(i), 4'(15 - i), 0, 0, 0, 0);
    tick();
    chk("global_clear_write_ignored", 9, 9, 0, 0, 0, 0);
    bus.C_EN = 0;
    RST = 0;
    tick();
    chk("global_clear_release", 9, 9, 0, 0, 0, 0);
    wr(15, 19'h7FFFF);
    chk("width_write", 15, 0, 19'h7FFFF, 0, 0, 0);
    mem_ld(8'hFF);
    chk("width_mem", 1, 15, 19'h000FF, 19'h7FFFF, 0, 8'hFF);
    #5;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-high, with ports named clk and RST.
REQ-002 clk  input  1  rising-edge clock for all register updates.
REQ-003 RST  input  1  asynchronous active-high clear; scope selected by RST_SEL.
REQ-004 RST_SEL  input  4  clear scope: 0 = all registers, 1..15 = only that register.
REQ-005 C_EN  input  1  write enable for the C write port.
REQ-006 C_SEL  input  4  C write port register index.
REQ-007 c_in  input  19  C write port data.
REQ-008 A_SEL  input  4  A read port register index.
REQ-009 B_SEL  input  4  B read port register index.
REQ-010 MEM_READ  input  1  load mem_data into R1 (DR) on the next rising edge.
REQ-011 mem_data  input  8  byte returned from data memory.
REQ-012 a_out  output  19  contents of R[A_SEL].
REQ-013 b_out  output  19  contents of R[B_SEL].
REQ-014 dm_addr  output  19  data-memory address, always R0 (AR).
REQ-015 dm_data  output  8  data-memory write byte, always R1[7:0] (DR).

Function
REQ-016 The block SHALL hold 16 registers R0..R15, each 19 bits; R0 is the address register AR, R1 the data register DR, and R2..R15 are general purpose.
REQ-017 On a rising clk edge with C_EN=1 and RST=0, R[C_SEL] SHALL take c_in; with C_EN=0, no register SHALL change except through MEM_READ.
REQ-018 On a rising clk edge with MEM_READ=1 and RST=0, R1 SHALL take {11'b0, mem_data}.
REQ-019 If MEM_READ=1 and C_EN=1 with C_SEL=1 on the same edge, the MEM_READ load SHALL win for R1.
REQ-020 If MEM_READ=1 and C_EN=1 with C_SEL≠1, both updates SHALL occur on the same edge.
REQ-021 a_out, b_out, dm_addr and dm_data SHALL be purely combinational from the register array.
REQ-022 A write SHALL become visible on the read ports only after the edge that performs it; there SHALL be no write-to-read bypass of c_in.
REQ-023 A_SEL and B_SEL SHALL be independent, and both may select the same register, including the register being written.
REQ-024 Write latency SHALL be one edge; read latency SHALL be zero cycles (combinational).

Reset
REQ-025 While RST=1 with RST_SEL=0, all 16 registers SHALL be cleared to 0 immediately, without waiting for a clock edge.
REQ-026 While RST=1 with RST_SEL=n (n≠0), only Rn SHALL be cleared immediately; all other registers SHALL keep their values.
REQ-027 RST SHALL dominate: while RST=1, any C_EN or MEM_READ update to a register being cleared SHALL be ignored.
REQ-028 While RST=1, C_EN and MEM_READ updates to registers not being cleared SHALL proceed normally.
REQ-029 Clearing SHALL take effect on an RST pulse of any width, including a zero-width pulse (RST and RST_SEL changing in the same time step).
REQ-030 Releasing RST SHALL NOT alter any register; the first clock edge after release SHALL perform normal writes.
REQ-031 After RST=1 with RST_SEL=0, all outputs SHALL read 0: a_out = b_out = dm_addr = 19'h0 and dm_data = 8'h0.
REQ-032 Register contents before the first reset SHALL be treated as unknown, and the bench SHALL NOT check them.

Verification
REQ-033 Write/read: RST with RST_SEL=0, then C_EN=1, C_SEL=1, c_in=10 for one edge, then C_EN=0, A_SEL=1, B_SEL=0 -> a_out=10, b_out=0, dm_data=8'd10, dm_addr=0.
REQ-034 Memory load: MEM_READ=1, mem_data=8'hA5, one edge -> R1=19'h000A5 and dm_data=8'hA5; then MEM_READ=1 and C_EN=1, C_SEL=1, c_in=7 on the same edge -> R1=mem_data.
REQ-035 Selective clear: load R0=0x7FFFF and R5=0x12345, pulse RST with RST_SEL=5 between edges -> R5=0 immediately and R0=0x7FFFF, so dm_addr=0x7FFFF.
REQ-036 Global async clear: fill all 16 registers, assert RST with RST_SEL=0 mid-cycle -> every register reads 0 before the next edge; a C_EN write asserted during RST is ignored.
REQ-037 No bypass: set A_SEL=B_SEL=3 and C_EN=1, C_SEL=3, c_in=0x55555 -> a_out and b_out show the old value until the edge, then both show 0x55555.
REQ-038 Width: write c_in=19'h7FFFF to R15 -> a_out reads 19'h7FFFF (no truncation); write mem_data=8'hFF via MEM_READ -> R1 reads 19'h000FF (upper bits zero).
